cpu_dcache_dm: RTL and testbench
================================

// Module: cpu_dcache_dm
// PURPOSE
//  Direct-mapped write-back, write-allocate cache sitting directly below the multicycle RV32I core.
//  Consumes the core's word-wide memory requests (mem_read/mem_write/byte enables) and serves hits locally.
//  Refills and evicts 32-byte lines over a 4-beat x 64-bit burst port to physical memory.
// PARAMETERS
//  S_INDEX   3   log2(number of sets); 8 lines; index = addr[S_INDEX+4:5]
//  S_OFFSET  5   log2(line bytes); fixed 32 B line, 4 bursts of 8 B
// PORTS
//  clk              in   1    single clock, rising edge
//  rst              in   1    asynchronous, active-high reset
//  mem_read         in   1    core read request; held until mem_resp
//  mem_write        in   1    core write request; held until mem_resp
//  mem_byte_enable  in   4    byte lanes for writes
//  mem_address      in   32   byte address; [1:0] ignored (word access)
//  mem_wdata        in   32   core write data
//  mem_resp         out  1    one-cycle pulse: request done
//  mem_rdata        out  32   read word; valid only while mem_resp=1
//  pmem_read        out  1    burst read request, held until 4th pmem_resp
//  pmem_write       out  1    burst write request, held until 4th pmem_resp
//  pmem_address     out  32   line address, [4:0]=0, stable through burst
//  pmem_wdata       out  64   write beat k = line bytes [8k+7:8k]
//  pmem_rdata       in   64   read beat, sampled when pmem_resp=1
//  pmem_resp        in   1    one pulse per beat, beats 0..3 in order
// BEHAVIOUR
//  Address split: tag=[31:8] (24 b), index=[7:5], word=[4:2].
//  Reset (async): state=IDLE, all valid/dirty=0, beat_cnt=0; mem_resp, pmem_read, pmem_write=0;
//    pmem_address/pmem_wdata/mem_rdata=0. Data/tag arrays not reset. Reset mid-burst aborts it
//    immediately; memory model must tolerate the dropped request.
//  FSM: IDLE -> COMPARE -> {IDLE | WRITEBACK | FILL}; WRITEBACK -> FILL; FILL -> COMPARE.
//  IDLE: if mem_read|mem_write, latch address/wdata/be/op into request regs, go COMPARE.
//  COMPARE: hit = valid[idx] & tag match.
//    hit read: mem_resp=1, mem_rdata=selected word (same cycle), -> IDLE.
//    hit write: mem_resp=1; at edge merge wdata per byte enable, set dirty[idx], -> IDLE.
//    miss & dirty -> WRITEBACK; miss & clean/invalid -> FILL.
//  Hit latency: 2 cycles from request assertion to mem_resp. IDLE-after-resp gives 1-cycle gap;
//    core must not re-present a request before that gap (multicycle control guarantees it).
//  WRITEBACK: pmem_write=1, pmem_address={old_tag,idx,5'b0}; pmem_wdata=beat beat_cnt;
//    each pmem_resp increments beat_cnt (2 b, wraps 3->0); on 4th resp clear dirty, -> FILL.
//  FILL: pmem_read=1, pmem_address={req_tag,idx,5'b0}; each pmem_resp writes beat beat_cnt
//    into line; on 4th resp set valid, tag, dirty=0, -> COMPARE (now guaranteed hit).
//  Miss latency (clean, memory responds 1/cycle): 2+4+1 = 7 cycles to mem_resp; dirty adds 4.
//  pmem_read and pmem_write never asserted together; mem_resp never asserted outside COMPARE.
//  mem_read & mem_write both high: illegal; assertion fires, write takes priority.
//  Request inputs are sampled only in IDLE; changes during a miss are ignored.
// STRUCTURE
//  Package cache_types: state_t enum {IDLE,COMPARE,WRITEBACK,FILL}, TAG_W=24, IDX_W=3,
//    LINE_W=256, BEAT_W=64, field-extract functions for tag/index/word.
//  Sub-module cache_data_array: 8 x 256 b, sync write, 32-bit byte-enable (per line byte) write
//    port plus async read; used for both hit merge and burst beat fill.
//  Tag/valid/dirty kept as flop arrays in top; FSM + beat counter in top.
// TESTING
//  1 Cold read 0x0000_0100, mem line = bytes 0x00..0x1F -> 4-beat FILL at pmem_address 0x100,
//    mem_rdata=0x03020100, mem_resp 7 cycles after request (1-cycle memory).
//  2 Write 0x0000_0104 be=4'b0110 data=0xAABBCCDD, then read 0x104 -> no pmem traffic,
//    rdata=0x07BBCC04, hit resp in 2 cycles.
//  3 Read 0x0000_1104 (same index 0, new tag) after test 2 -> WRITEBACK to 0x100 with beat0
//    wdata=0x07BBCC04_03020100, then FILL 0x1100; dirty clears.
//  4 Assert rst during beat 2 of a FILL -> pmem_read drops same cycle, mem_resp stays 0,
//    next read of that address misses again (valid=0).
//  5 Random 2000-op read/write stream over 64 KB vs. flat golden memory; pmem_resp with 0-5
//    cycle random delays -> every mem_rdata matches golden; pmem_read&pmem_write never both 1.

Source files
------------

// File: rtl/cpu_dcache_dm_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
// 32 B lines, 8 sets, 24-bit tags; refills move 4 beats of 64 bits.
package cache_types;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    localparam int TAG_W      = 24;
    localparam int IDX_W      = 3;
    localparam int WORD_W     = 3;
    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 64;
    localparam int LINE_BYTES = 32;

    function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
        return addr[31:8];
    endfunction

    function automatic logic [IDX_W-1:0] get_index(input logic [31:0] addr);
        return addr[7:5];
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/cpu_dcache_dm_data_array.sv
// Line storage: 8 x 256 b, per-byte write enables, combinational read of the indexed line.
// Serves both core-word merges and 64-bit refill beats through the same write port.
module cache_data_array
    import cache_types::*;
(
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [LINE_BYTES-1:0] i_be,
    input  logic [LINE_W-1:0]     i_wdata,
    output logic [LINE_W-1:0]     o_rdata
);

    logic [LINE_W-1:0] r_lines [2**IDX_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (i_be[b]) r_lines[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_lines[i_idx];

endmodule

// File: rtl/cpu_dcache_dm.sv
// Direct-mapped write-back/write-allocate D-cache: hit responds 2 cycles after request,
// clean miss 7 cycles, dirty miss 11 (1 beat/cycle memory); core holds its request until mem_resp.
module cpu_dcache_dm
    import cache_types::*;
#(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [63:0] pmem_wdata,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int SETS = 1 << S_INDEX;

    state_t            r_state;
    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag [SETS];
    logic [1:0]        r_beat_cnt;
    logic [31:0]       r_req_addr;
    logic [31:0]       r_req_wdata;
    logic [3:0]        r_req_be;
    logic              r_req_write;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic [WORD_W-1:0]     w_word;
    logic [LINE_W-1:0]     w_line;
    logic                  w_hit;
    logic                  w_arr_we;
    logic [LINE_BYTES-1:0] w_arr_be;
    logic [LINE_W-1:0]     w_arr_wdata;

    assign w_idx     = get_index(r_req_addr);
    assign w_req_tag = get_tag(r_req_addr);
    assign w_word    = get_word(r_req_addr);
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);

    cache_data_array u_data (
        .i_clk   (clk),
        .i_we    (w_arr_we),
        .i_idx   (w_idx),
        .i_be    (w_arr_be),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_line)
    );

    // Outputs decode from the registered state, so an async reset drops them immediately.
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_arr_we     = 1'b0;
        w_arr_be     = '0;
        w_arr_wdata  = '0;
        case (r_state)
            COMPARE: begin
                if (w_hit) begin
                    mem_resp  = 1'b1;
                    mem_rdata = w_line[{w_word, 5'b0} +: 32];
                    if (r_req_write) begin
                        w_arr_we    = 1'b1;
                        w_arr_be    = LINE_BYTES'({28'b0, r_req_be}) << {w_word, 2'b0};
                        w_arr_wdata = {8{r_req_wdata}};
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx], w_idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = w_line[{r_beat_cnt, 6'b0} +: BEAT_W];
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_req_tag, w_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    w_arr_we    = 1'b1;
                    w_arr_be    = LINE_BYTES'(32'hFF) << {r_beat_cnt, 3'b0};
                    w_arr_wdata = {4{pmem_rdata}};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_beat_cnt  <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_be    <= '0;
            r_req_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        r_req_addr  <= mem_address;
                        r_req_wdata <= mem_wdata;
                        r_req_be    <= mem_byte_enable;
                        r_req_write <= mem_write;
                        r_state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        if (r_req_write) r_dirty[w_idx] <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        r_state <= WRITEBACK;
                    end else begin
                        r_state <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        r_beat_cnt <= r_beat_cnt + 2'd1;
                        if (r_beat_cnt == 2'd3) begin
                            r_dirty[w_idx] <= 1'b0;
                            r_state        <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_beat_cnt <= r_beat_cnt + 2'd1;
                        if (r_beat_cnt == 2'd3) begin
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b0;
                            r_state        <= COMPARE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == FILL && pmem_resp && r_beat_cnt == 2'd3) r_tag[w_idx] <= w_req_tag;
    end

    // Simultaneous read and write is a core bug; the write wins in IDLE.
    assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_cpu_dcache_dm.sv
// Directed bench for cpu_dcache_dm with a burst memory model and a flat golden word memory.
module tb_cpu_dcache_dm;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    cpu_dcache_dm dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    logic [63:0] pm [8192];
    logic [31:0] gm [16384];

    int          max_delay = 0;
    logic [1:0]  m_beat    = 2'd0;
    int          m_wait    = 0;
    logic [12:0] m_idx;
    int          rd_beats  = 0;
    int          wr_beats  = 0;
    logic [31:0] last_fill_addr = '0;
    logic [31:0] last_wb_addr   = '0;
    logic [63:0] last_wb_beat0  = '0;
    logic        both_seen      = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int unsigned a, input int mode);
        int unsigned v;
        v = (a ^ (a >> 7)) * 29 + 3;
        return (mode == 0) ? a[7:0] : v[7:0];
    endfunction

    task automatic init_mem(input int mode);
        for (int w = 0; w < 8192; w++) begin
            for (int b = 0; b < 8; b++) begin
                pm[w][8*b +: 8]                 = pat(32'(w*8 + b), mode);
                gm[(w*8 + b) / 4][8*(b%4) +: 8] = pat(32'(w*8 + b), mode);
            end
        end
    endtask

    // Burst memory: one beat per resp pulse, random gap of 0..max_delay cycles before each beat.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if (!rst && (pmem_read || pmem_write)) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else begin
                    m_idx = {pmem_address[15:5], m_beat};
                    if (pmem_write) begin
                        if (m_beat == 2'd0) begin
                            last_wb_beat0 = pmem_wdata;
                            last_wb_addr  = pmem_address;
                        end
                        pm[m_idx] = pmem_wdata;
                        wr_beats++;
                    end else begin
                        pmem_rdata     = pm[m_idx];
                        last_fill_addr = pmem_address;
                        rd_beats++;
                    end
                    pmem_resp = 1'b1;
                    m_beat    = m_beat + 2'd1;
                    m_wait    = $urandom_range(max_delay, 0);
                end
            end else begin
                m_beat = 2'd0;
                m_wait = $urandom_range(max_delay, 0);
            end
        end
    end

    // One core transaction; cyc counts clock edges from request to the edge that samples mem_resp.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        int n;
        logic got;
        @(negedge clk);
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        got = 1'b0;
        n   = 0;
        rd  = '0;
        cyc = -1;
        while (!got && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mem_resp) begin
                got = 1'b1;
                rd  = mem_rdata;
                cyc = n + 1;
            end
        end
        chk("resp_seen", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    logic [31:0] rd;
    int          cyc;
    int          rb0;
    int          wb0;
    int          n;
    logic        wr;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;

    initial begin
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_address     = '0;
        mem_wdata       = '0;
        init_mem(0);
        repeat (3) @(negedge clk);

        chk("rst_mem_resp",   64'(mem_resp),     64'(0));
        chk("rst_mem_rdata",  64'(mem_rdata),    64'(0));
        chk("rst_pmem_read",  64'(pmem_read),    64'(0));
        chk("rst_pmem_write", 64'(pmem_write),   64'(0));
        chk("rst_pmem_addr",  64'(pmem_address), 64'(0));
        chk("rst_pmem_wdata", pmem_wdata,        64'(0));
        rst = 1'b0;

        // Cold read miss.
        rb0 = rd_beats; wb0 = wr_beats;
        do_req(1'b0, 32'h0000_0100, 4'h0, 32'h0, rd, cyc);
        chk("t1_cycles",    64'(cyc),            64'(7));
        chk("t1_rdata",     64'(rd),             64'h0302_0100);
        chk("t1_fill_addr", 64'(last_fill_addr), 64'h100);
        chk("t1_rd_beats",  64'(rd_beats - rb0), 64'(4));
        chk("t1_wr_beats",  64'(wr_beats - wb0), 64'(0));

        // Partial write hit, then read hit.
        rb0 = rd_beats; wb0 = wr_beats;
        do_req(1'b1, 32'h0000_0104, 4'b0110, 32'hAABB_CCDD, rd, cyc);
        chk("t2_wr_cycles", 64'(cyc), 64'(2));
        do_req(1'b0, 32'h0000_0104, 4'h0, 32'h0, rd, cyc);
        chk("t2_rd_cycles", 64'(cyc), 64'(2));
        chk("t2_rdata",     64'(rd),  64'h07BB_CC04);
        chk("t2_pmem_none", 64'((rd_beats - rb0) + (wr_beats - wb0)), 64'(0));

        // Conflict miss on a dirty line: writeback then fill.
        rb0 = rd_beats; wb0 = wr_beats;
        do_req(1'b0, 32'h0000_1104, 4'h0, 32'h0, rd, cyc);
        chk("t3_cycles",    64'(cyc),            64'(11));
        chk("t3_rdata",     64'(rd),             64'h0706_0504);
        chk("t3_wb_addr",   64'(last_wb_addr),   64'h100);
        chk("t3_wb_beat0",  last_wb_beat0,       64'h07BB_CC04_0302_0100);
        chk("t3_wr_beats",  64'(wr_beats - wb0), 64'(4));
        chk("t3_fill_addr", 64'(last_fill_addr), 64'h1100);
        chk("t3_mem_line",  pm[32],              64'h07BB_CC04_0302_0100);

        // Evicting the now-clean line must not write back.
        rb0 = rd_beats; wb0 = wr_beats;
        do_req(1'b0, 32'h0000_0104, 4'h0, 32'h0, rd, cyc);
        chk("t3_clean_cycles", 64'(cyc),            64'(7));
        chk("t3_clean_rdata",  64'(rd),             64'h07BB_CC04);
        chk("t3_clean_nowb",   64'(wr_beats - wb0), 64'(0));

        // Reset in the middle of a refill.
        rb0 = rd_beats;
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h0000_02A0;
        n = 0;
        while ((rd_beats - rb0) < 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t4_at_beat2",    64'(rd_beats - rb0), 64'(3));
        chk("t4_pre_rst_rd",  64'(pmem_read),      64'(1));
        rst = 1'b1;
        #1;
        chk("t4_rst_rd_drop", 64'(pmem_read),      64'(0));
        chk("t4_rst_addr",    64'(pmem_address),   64'(0));
        chk("t4_rst_resp",    64'(mem_resp),       64'(0));
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_rst_resp_hold", 64'(mem_resp), 64'(0));
        rst = 1'b0;
        rb0 = rd_beats;
        do_req(1'b0, 32'h0000_02A0, 4'h0, 32'h0, rd, cyc);
        chk("t4_remiss_cycles", 64'(cyc),            64'(7));
        chk("t4_remiss_beats",  64'(rd_beats - rb0), 64'(4));
        chk("t4_remiss_rdata",  64'(rd),             64'hA3A2_A1A0);

        // Random read/write stream with random memory latency.
        @(negedge clk);
        rst = 1'b1;
        init_mem(1);
        max_delay = 5;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            wr = 1'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 0) a = 32'($urandom_range(255, 0)) << 2;
            else                           a = 32'($urandom_range(16383, 0)) << 2;
            be = 4'($urandom_range(15, 0));
            wd = $urandom;
            do_req(wr, a, be, wd, rd, cyc);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) gm[a[15:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                chk("t5_rdata", 64'(rd), 64'(gm[a[15:2]]));
            end
        end
        chk("t5_rw_exclusive", 64'(both_seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
